c64_bus_arbiter: RTL and testbench

- Sequences ownership of the shared C64 system bus between the 6510 CPU, the VIC-II and expansion-port DMA.
- Generates BA (fed to the CPU RDY input) and AEC (CPU address/data enable) with the 6510-mandated warning period before the CPU loses phi2.
- Sits beside the CPU wrapper and VIC; the VIC always owns phi1, and this block decides who owns each phi2 half-cycle.

---
 rtl/c64_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_c64_bus_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/c64_bus_arbiter.sv
// C64 system bus arbiter: hands each phi2 half to the CPU, the VIC-II or expansion DMA, with BA warning.
// Optional stolen-cycle counter enabled by defining C64_BUS_STEAL_STATS_EN.
module c64_bus_arbiter #(
  parameter int WARN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ph1_start,
  input  logic        ph2_start,
  input  logic        vic_req,
  input  logic        ext_req,
  output logic        ba,
  output logic        aec,
  output logic        vic_grant,
  output logic        ext_grant,
  input  logic        stats_clr,
  output logic [15:0] steal_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARN,
    S_VIC,
    S_EXT
  } state_t;

  typedef enum logic {
    OWN_VIC,
    OWN_EXT
  } owner_t;

  localparam logic [2:0] LAST_WARN = 3'(WARN_CYCLES - 1);

  state_t     state;
  owner_t     pending_owner;
  logic [2:0] warn_cnt;
  owner_t     pick;

  // VIC outranks expansion DMA; with no request the previous choice is kept.
  always_comb begin
    pick = pending_owner;
    if (vic_req) begin
      pick = OWN_VIC;
    end else if (ext_req) begin
      pick = OWN_EXT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      pending_owner <= OWN_VIC;
      warn_cnt      <= '0;
      ba            <= 1'b1;
      aec           <= 1'b0;
      vic_grant     <= 1'b0;
      ext_grant     <= 1'b0;
    end else if (ph1_start) begin
      aec <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vic_req || ext_req) begin
            state         <= S_WARN;
            pending_owner <= pick;
            warn_cnt      <= '0;
            ba            <= 1'b0;
          end
        end
        S_WARN: begin
          if (!vic_req && !ext_req) begin
            state    <= S_IDLE;
            ba       <= 1'b1;
            warn_cnt <= '0;
          end else begin
            // Owner may switch mid-warning; the CPU has already seen BA low, so cnt keeps running.
            pending_owner <= pick;
            if (warn_cnt == LAST_WARN) begin
              warn_cnt <= '0;
              if (pick == OWN_VIC) begin
                state     <= S_VIC;
                vic_grant <= 1'b1;
              end else begin
                state     <= S_EXT;
                ext_grant <= 1'b1;
              end
            end else begin
              warn_cnt <= warn_cnt + 3'd1;
            end
          end
        end
        S_VIC: begin
          if (!vic_req) begin
            vic_grant <= 1'b0;
            if (ext_req) begin
              // CPU is already halted, so DMA takes over without a fresh warning.
              state         <= S_EXT;
              pending_owner <= OWN_EXT;
              ext_grant     <= 1'b1;
            end else begin
              state <= S_IDLE;
              ba    <= 1'b1;
            end
          end
        end
        S_EXT: begin
          if (vic_req) begin
            state         <= S_VIC;
            pending_owner <= OWN_VIC;
            ext_grant     <= 1'b0;
            vic_grant     <= 1'b1;
          end else if (!ext_req) begin
            state     <= S_IDLE;
            ext_grant <= 1'b0;
            ba        <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          ba        <= 1'b1;
          vic_grant <= 1'b0;
          ext_grant <= 1'b0;
          warn_cnt  <= '0;
        end
      endcase
    end else if (ph2_start) begin
      aec <= (state == S_IDLE) || (state == S_WARN);
    end
  end

`ifdef C64_BUS_STEAL_STATS_EN
  logic steal_tick;

  // A steal is any ph1 decision whose resulting state is VIC or EXT.
  always_comb begin
    steal_tick = ph1_start && (vic_req || ext_req) &&
                 ((state == S_VIC) || (state == S_EXT) ||
                  ((state == S_WARN) && (warn_cnt == LAST_WARN)));
  end

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      steal_count <= '0;
    end else if (steal_tick && (steal_count != 16'hFFFF)) begin
      steal_count <= steal_count + 16'd1;
    end
  end
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign steal_count      = '0;
`endif

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Directed testbench for c64_bus_arbiter; outputs checked as {ba,aec,vic_grant,ext_grant}.
// Stolen-cycle counter checks follow C64_BUS_STEAL_STATS_EN.
module tb_c64_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ph1_start = 1'b0;
  logic        ph2_start = 1'b0;
  logic        vic_req = 1'b0;
  logic        ext_req = 1'b0;
  logic        stats_clr = 1'b0;
  logic        ba;
  logic        aec;
  logic        vic_grant;
  logic        ext_grant;
  logic [15:0] steal_count;

  int vectors = 0;
  int miscompares = 0;

  c64_bus_arbiter #(.WARN_CYCLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .ph1_start  (ph1_start),
    .ph2_start  (ph2_start),
    .vic_req    (vic_req),
    .ext_req    (ext_req),
    .ba         (ba),
    .aec        (aec),
    .vic_grant  (vic_grant),
    .ext_grant  (ext_grant),
    .stats_clr  (stats_clr),
    .steal_count(steal_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic e);
    @(negedge clk);
    vic_req = v;
    ext_req = e;
  endtask

  // Each strobe is high for exactly one posedge; outputs are sampled on the following negedge.
  task automatic doPh1();
    @(negedge clk);
    ph1_start = 1'b1;
    @(negedge clk);
    ph1_start = 1'b0;
  endtask

  task automatic doPh2();
    @(negedge clk);
    ph2_start = 1'b1;
    @(negedge clk);
    ph2_start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {ba, aec, vic_grant, ext_grant};
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag, input logic [15:0] expected);
    vectors++;
    assert (steal_count === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, steal_count, expected);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 4'b1000);
    checkCount("reset_count", 16'd0);
    reset = 1'b0;
    doPh2();
    checkOutput("idle_ph2_aec", 4'b1100);

    // Basic steal, WARN_CYCLES=3
    applyStimulus(1'b1, 1'b0);
    doPh1(); checkOutput("steal_n_ph1", 4'b0000);
    doPh2(); checkOutput("steal_n_ph2", 4'b0100);
    doPh1(); checkOutput("steal_n1_ph1", 4'b0000);
    doPh2(); checkOutput("steal_n1_ph2", 4'b0100);
    doPh1(); checkOutput("steal_n2_ph1", 4'b0000);
    doPh2(); checkOutput("steal_n2_ph2", 4'b0100);
    doPh1(); checkOutput("steal_n3_ph1", 4'b0010);
    doPh2(); checkOutput("steal_n3_ph2", 4'b0010);
    applyStimulus(1'b0, 1'b0);
    doPh1(); checkOutput("release_ph1", 4'b1000);
    doPh2(); checkOutput("release_ph2", 4'b1100);

    // Aborted warning
    applyStimulus(1'b1, 1'b0);
    doPh1(); checkOutput("abort_warn_ph1", 4'b0000);
    doPh2(); checkOutput("abort_warn_ph2", 4'b0100);
    applyStimulus(1'b0, 1'b0);
    doPh1(); checkOutput("abort_idle_ph1", 4'b1000);
    doPh2(); checkOutput("abort_idle_ph2", 4'b1100);

    // Request seen only between ph1 strobes is ignored
    applyStimulus(1'b1, 1'b0);
    doPh2(); checkOutput("glitch_ph2", 4'b1100);
    applyStimulus(1'b0, 1'b0);
    doPh1(); checkOutput("glitch_ph1", 4'b1000);

    // Coincident strobes behave as ph1 only
    doPh2();
    @(negedge clk);
    ph1_start = 1'b1;
    ph2_start = 1'b1;
    @(negedge clk);
    ph1_start = 1'b0;
    ph2_start = 1'b0;
    checkOutput("coincident_strobe", 4'b1000);

    // Pending owner switches EXT -> VIC without restarting the warning
    applyStimulus(1'b0, 1'b1);
    doPh1(); checkOutput("prio_n_ph1", 4'b0000);
    doPh2(); checkOutput("prio_n_ph2", 4'b0100);
    applyStimulus(1'b1, 1'b1);
    doPh1(); checkOutput("prio_n1_ph1", 4'b0000);
    doPh1(); checkOutput("prio_n2_ph1", 4'b0000);
    doPh1(); checkOutput("prio_n3_vic", 4'b0010);
    applyStimulus(1'b0, 1'b1);
    doPh1(); checkOutput("handoff_ext", 4'b0001);
    doPh2(); checkOutput("handoff_ext_ph2", 4'b0001);

    // Preemption of EXT by VIC
    applyStimulus(1'b1, 1'b1);
    doPh1(); checkOutput("preempt_vic", 4'b0010);
    applyStimulus(1'b0, 1'b1);
    doPh1(); checkOutput("back_to_ext", 4'b0001);
    applyStimulus(1'b0, 1'b0);
    doPh1(); checkOutput("ext_release", 4'b1000);
    doPh2(); checkOutput("ext_release_ph2", 4'b1100);
`ifndef C64_BUS_STEAL_STATS_EN
    checkCount("count_tied_zero", 16'd0);
`endif

    // Reset in the middle of a VIC steal
    applyStimulus(1'b1, 1'b0);
    repeat (4) doPh1();
    checkOutput("pre_reset_vic", 4'b0010);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("midsteal_reset", 4'b1000);
    checkCount("midsteal_reset_count", 16'd0);
    doPh2(); checkOutput("post_reset_ph2", 4'b1100);

`ifdef C64_BUS_STEAL_STATS_EN
    applyStimulus(1'b1, 1'b0);
    repeat (43) doPh1();
    checkCount("count_40", 16'd40);
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checkCount("count_clear", 16'd0);
    doPh1();
    checkCount("count_after_clear", 16'd1);
    @(negedge clk);
    ph1_start = 1'b1;
    repeat (65540) @(negedge clk);
    ph1_start = 1'b0;
    checkCount("count_saturate", 16'hFFFF);
    checkOutput("sat_still_vic", 4'b0010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
